// File: rtl/bell_scheduler.sv
// Bell scheduler: turns request edges into pending flags and launches one bell at a
// time on a tone generator, round-robin across sources, with an enforced idle gap.
module bell_scheduler #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned GAP_CYCLES    = 2500000,
   parameter int unsigned START_TIMEOUT = 15
) (
   input  logic               clk_50_i,
   input  logic               reset_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               mute_i,
   input  logic               bell_done_i,
   output logic               bell_trigger_o,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [3:0]         pending_o,
   output logic               busy_o,
   output logic               overflow_o
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(START_TIMEOUT + 1);
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIGGER,
      S_WAIT_START,
      S_PLAY,
      S_GAP
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_REQ-1:0] r_req_q;
   logic [NUM_REQ-1:0] r_pend;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] w_grant_nxt;
   logic [NUM_REQ-1:0] w_edge;
   logic [NUM_REQ-1:0] w_drop;
   logic [NUM_REQ-1:0] w_clear;
   logic [NUM_REQ-1:0] w_pend_nxt;
   logic [NUM_REQ-1:0] w_win_oh;
   logic               r_armed;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_found;
   logic               w_launch;
   logic [TO_W-1:0]    r_to_cnt;
   logic [TO_W-1:0]    w_to_nxt;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [GAP_W-1:0]   w_gap_nxt;
   logic [3:0]         w_pend_cnt;
   logic [3:0]         r_pend_cnt;
   logic               r_trig;
   logic               r_busy;
   logic               r_ovf;

   // Round-robin pick: first pending source after the last winner.
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!w_win_found && r_pend[IDX_W'((32'(r_ptr) + k) % NUM_REQ)]) begin
            w_win_found = 1'b1;
            w_win_idx   = IDX_W'((32'(r_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign w_win_oh = NUM_REQ'(1) << w_win_idx;

   // Pending flags; a set wins over a same-cycle grant-clear. Edges are
   // suppressed on the first clock after reset so held-high lines stay quiet.
   always_comb begin
      w_edge     = r_armed ? (req_i & ~r_req_q) : '0;
      w_clear    = w_launch ? w_win_oh : '0;
      w_drop     = w_edge & r_pend & ~w_clear;
      w_pend_nxt = (r_pend & ~w_clear) | w_edge;
      w_pend_cnt = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_pend_cnt = w_pend_cnt + 4'(w_pend_nxt[k]);
      end
   end

   // Next-state and counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_to_nxt    = r_to_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_grant_nxt = r_grant;
      w_launch    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((|r_pend) && !mute_i && bell_done_i) begin
               w_launch    = 1'b1;
               w_grant_nxt = w_win_oh;
               w_state_nxt = S_TRIGGER;
            end
         end
         S_TRIGGER: begin
            w_to_nxt    = '0;
            w_state_nxt = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (!bell_done_i) begin
               w_state_nxt = S_PLAY;
            end else if (r_to_cnt == TO_W'(START_TIMEOUT - 1)) begin
               w_gap_nxt   = GAP_W'(GAP_CYCLES - 1);
               w_state_nxt = S_GAP;
            end else begin
               w_to_nxt = r_to_cnt + TO_W'(1);
            end
         end
         S_PLAY: begin
            if (bell_done_i) begin
               w_gap_nxt   = GAP_W'(GAP_CYCLES - 1);
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == '0) begin
               w_grant_nxt = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt - GAP_W'(1);
            end
         end
         default: begin
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and outputs, registered from next-state values so they align with the state.
   always_ff @(posedge clk_50_i or posedge reset_i) begin
      if (reset_i) begin
         r_req_q    <= '0;
         r_armed    <= 1'b0;
         r_pend     <= '0;
         r_ptr      <= IDX_W'(NUM_REQ - 1);
         r_to_cnt   <= '0;
         r_gap_cnt  <= '0;
         r_grant    <= '0;
         r_pend_cnt <= '0;
         r_trig     <= 1'b0;
         r_busy     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_req_q    <= req_i;
         r_armed    <= 1'b1;
         r_pend     <= w_pend_nxt;
         if (w_launch) begin
            r_ptr <= w_win_idx;
         end
         r_to_cnt   <= w_to_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_grant    <= w_grant_nxt;
         r_pend_cnt <= w_pend_cnt;
         r_trig     <= (w_state_nxt == S_TRIGGER);
         r_busy     <= (w_state_nxt != S_IDLE);
         r_ovf      <= |w_drop;
      end
   end

   assign bell_trigger_o = r_trig;
   assign grant_o        = r_grant;
   assign pending_o      = r_pend_cnt;
   assign busy_o         = r_busy;
   assign overflow_o     = r_ovf;

endmodule

// File: tb/tb_bell_scheduler.sv
// Bench for bell_scheduler: table vectors, directed corner sequences and random
// stimulus, all checked against a transaction-level model with a simple tone generator.
module tb_bell_scheduler;

   localparam int N   = 4;
   localparam int GAP = 8;
   localparam int ST  = 15;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] req  = 4'b0000;
   logic       mute = 1'b0;
   logic       done;
   logic       trig;
   logic [3:0] grant;
   logic [3:0] pend;
   logic       busy;
   logic       ovf;

   int n_checks = 0;
   int n_fail   = 0;
   int len_sel  = 2;

   bell_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .START_TIMEOUT(ST)) dut (
      .clk_50_i      (clk),
      .reset_i       (rst),
      .req_i         (req),
      .mute_i        (mute),
      .bell_done_i   (done),
      .bell_trigger_o(trig),
      .grant_o       (grant),
      .pending_o     (pend),
      .busy_o        (busy),
      .overflow_o    (ovf)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [3:0] m_pend = 4'b0, m_prev = 4'b0, m_grant = 4'b0;
   logic [3:0] m_edges, m_clr, m_drop;
   logic       m_armed = 1'b0, m_trig = 1'b0, m_ovf = 1'b0, m_busy = 1'b0;
   logic       m_launch, m_found;
   int         m_ptr = N - 1, m_len = 0, m_w;
   longint     m_cyc = 0, m_idle_at = 0;

   // Tone generator: sees the trigger one clock late, then stays busy m_len cycles.
   logic trig_d = 1'b0;
   int   tone_cnt = 0;
   always @(posedge clk) begin
      trig_d <= trig;
      if (trig_d) tone_cnt <= m_len;
      else if (tone_cnt != 0) tone_cnt <= tone_cnt - 1;
   end
   assign done = (tone_cnt == 0);

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: per-clock pending/overflow rules; a bell occupies a fixed span computed from its length.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_pend = 0; m_prev = 0; m_grant = 0; m_armed = 0;
         m_trig = 0; m_ovf = 0; m_busy = 0; m_ptr = N - 1;
         m_cyc = 0; m_idle_at = 0;
      end else begin
         m_edges  = m_armed ? (req & ~m_prev) : 4'b0;
         m_prev   = req;
         m_armed  = 1'b1;
         m_launch = !m_busy && (m_pend != 0) && !mute && done;
         m_clr    = 4'b0;
         if (m_launch) begin
            m_found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               m_w = (m_ptr + k) % N;
               if (!m_found && m_pend[m_w]) begin
                  m_found    = 1'b1;
                  m_clr[m_w] = 1'b1;
                  m_ptr      = m_w;
               end
            end
            m_grant = m_clr;
            m_len   = len_sel;
         end
         m_drop = m_edges & m_pend & ~m_clr;
         m_ovf  = (m_drop != 0);
         m_pend = (m_pend & ~m_clr) | m_edges;
         m_trig = m_launch;
         m_cyc++;
         if (m_launch)
            m_idle_at = m_cyc + ((m_len > 0) ? (3 + m_len + GAP) : (1 + ST + GAP));
         m_busy = (m_cyc < m_idle_at);
         if (!m_busy) m_grant = 0;
      end
   end

   // Continuous cycle-by-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("mdl_trigger", int'(trig), int'(m_trig));
         chk("mdl_grant", int'(grant), int'(m_grant));
         chk("mdl_pending", int'(pend), $countones(m_pend));
         chk("mdl_busy", int'(busy), int'(m_busy));
         chk("mdl_overflow", int'(ovf), int'(m_ovf));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_trig(input string name);
      int w;
      w = 0;
      while (trig !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk(name, int'(trig), 1);
   endtask

   task automatic wait_idle(input string name, input int exp_len);
      int c, extra;
      c = 0;
      extra = 0;
      while (busy === 1'b1 && c < 300) begin
         @(negedge clk);
         c++;
         if (trig) extra++;
      end
      chk({name, "_len"}, c, exp_len);
      chk({name, "_extra_trig"}, extra, 0);
      chk({name, "_grant_clr"}, int'(grant), 0);
   endtask

   typedef struct {
      logic [3:0] req;
      logic       mute;
      int         pend;
      logic       ovf;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, gseen, b;
      tbl[0] = '{4'b0000, 1'b1, 0, 1'b0};
      tbl[1] = '{4'b0001, 1'b1, 1, 1'b0};
      tbl[2] = '{4'b0000, 1'b1, 1, 1'b0};
      tbl[3] = '{4'b0001, 1'b1, 1, 1'b1};
      tbl[4] = '{4'b0110, 1'b1, 3, 1'b0};
      tbl[5] = '{4'b0000, 1'b1, 3, 1'b0};
      tbl[6] = '{4'b0111, 1'b1, 3, 1'b1};
      tbl[7] = '{4'b1111, 1'b1, 4, 1'b0};
      tbl[8] = '{4'b1111, 1'b1, 4, 1'b0};
      tbl[9] = '{4'b0000, 1'b1, 4, 1'b0};

      repeat (3) tick();
      chk("rst_trigger", int'(trig), 0);
      chk("rst_grant", int'(grant), 0);
      chk("rst_pending", int'(pend), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overflow", int'(ovf), 0);
      rst = 1'b0;

      // Edge detection, drops and counting while muted
      for (int i = 0; i < 10; i++) begin
         req  = tbl[i].req;
         mute = tbl[i].mute;
         tick();
         chk($sformatf("tbl%0d_pending", i), int'(pend), tbl[i].pend);
         chk($sformatf("tbl%0d_overflow", i), int'(ovf), int'(tbl[i].ovf));
         chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
      end

      // Round-robin from reset pointer
      mute = 1'b0;
      len_sel = 2;
      for (int g = 0; g < 4; g++) begin
         wait_trig("rr_trig");
         chk("rr_grant", int'(grant), 1 << g);
         chk("rr_pending", int'(pend), 3 - g);
         wait_idle("rr_idle", 13);
      end

      // Single request, 20-cycle tone
      len_sel = 20;
      req = 4'b0100;
      wait_trig("single_trig");
      chk("single_grant", int'(grant), 4);
      chk("single_pending", int'(pend), 0);
      wait_idle("single_idle", 31);

      // Start timeout, then next pending source proceeds
      len_sel = 0;
      req = 4'b0111;
      wait_trig("to_trig");
      chk("to_grant", int'(grant), 1);
      chk("to_pending", int'(pend), 1);
      len_sel = 3;
      wait_idle("to_idle", 24);
      wait_trig("to_next_trig");
      chk("to_next_grant", int'(grant), 2);
      chk("to_next_pending", int'(pend), 0);
      wait_idle("to_next_idle", 14);

      // Overflow while muted
      mute = 1'b1;
      req = 4'b0000; tick();
      req = 4'b0010; tick();
      chk("ovf_first_pending", int'(pend), 1);
      chk("ovf_first_overflow", int'(ovf), 0);
      req = 4'b0000; tick();
      req = 4'b0010; tick();
      chk("ovf_drop_overflow", int'(ovf), 1);
      chk("ovf_drop_pending", int'(pend), 1);
      req = 4'b0000; tick();
      chk("ovf_pulse_width", int'(ovf), 0);
      mute = 1'b0;
      len_sel = 2;
      n = 0;
      gseen = 0;
      repeat (40) begin
         tick();
         if (trig) begin
            n++;
            gseen = int'(grant);
         end
      end
      chk("ovf_bell_count", n, 1);
      chk("ovf_bell_grant", gseen, 2);
      chk("ovf_end_pending", int'(pend), 0);

      // Same-cycle set and grant-clear on source 0
      req = 4'b1000;
      wait_trig("sc_pre_trig");
      chk("sc_pre_grant", int'(grant), 8);
      wait_idle("sc_pre_idle", 13);
      mute = 1'b1;
      req = 4'b1001; tick();
      req = 4'b1000; tick();
      req = 4'b1010; tick();
      chk("sc_setup_pending", int'(pend), 2);
      mute = 1'b0;
      req = 4'b1011;
      tick();
      chk("sc_trigger", int'(trig), 1);
      chk("sc_grant", int'(grant), 1);
      chk("sc_overflow", int'(ovf), 0);
      chk("sc_pending", int'(pend), 2);
      wait_idle("sc_idle0", 13);
      wait_trig("sc_trig1");
      chk("sc_grant1", int'(grant), 2);
      wait_idle("sc_idle1", 13);
      wait_trig("sc_trig2");
      chk("sc_grant2", int'(grant), 1);
      chk("sc_pending2", int'(pend), 0);
      wait_idle("sc_idle2", 13);

      // Reset in the middle of a bell with two sources pending
      len_sel = 40;
      req = 4'b0000; tick();
      req = 4'b0100;
      wait_trig("mr_trig");
      req = 4'b0111;
      repeat (6) tick();
      chk("mr_busy_before", int'(busy), 1);
      chk("mr_pending_before", int'(pend), 2);
      #2 rst = 1'b1;
      #1;
      chk("mr_async_trigger", int'(trig), 0);
      chk("mr_async_grant", int'(grant), 0);
      chk("mr_async_pending", int'(pend), 0);
      chk("mr_async_busy", int'(busy), 0);
      chk("mr_async_overflow", int'(ovf), 0);
      tick();
      tick();
      rst = 1'b0;
      n = 0;
      repeat (100) begin
         tick();
         if (trig) n++;
      end
      chk("mr_no_trigger", n, 0);
      chk("mr_pending_after", int'(pend), 0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            b = int'($urandom_range(0, 3));
            req[b] = ~req[b];
         end
         if ($urandom_range(0, 19) == 0) mute = ~mute;
         len_sel = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
         rst = (i == 1500);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
